zynq_pl_to_ps_packet_arbiter: RTL and testbench
===============================================

// Module: zynq_pl_to_ps_packet_arbiter
// PURPOSE
//  Shares one PL->PS FIFO of bsg_zynq_pl_shell among num_req_p PL-side producers.
//  Each grant emits a header word (source id, payload length), then the granted
//  requester's payload words, with no interleaving. Round-robin between packets.
//  Sits between accelerator producers and the shell's pl_to_ps_fifo_{data,v,ready}.
// PARAMETERS
//  num_req_p      4   number of requesters (1..256)
//  data_width_p   32  word width; equals C_S00_AXI_DATA_WIDTH (>=24)
//  max_len_p      16  max payload words per packet (<65536); lg_len_lp=$clog2(max_len_p+1)
// PORTS
//  aclk          in   1                      clock
//  aresetn       in   1                      reset, asynchronous, active-low
//  req_v_i       in   num_req_p              requester has a word/packet pending
//  req_data_i    in   num_req_p*data_width_p payload word per requester
//  req_len_i     in   num_req_p*lg_len_lp    payload length, valid whenever req_v_i
//  req_yumi_o    out  num_req_p              payload word consumed this cycle
//  fifo_data_o   out  data_width_p           to shell pl_to_ps_fifo_data_i
//  fifo_v_o      out  1                      to shell pl_to_ps_fifo_v_i
//  fifo_ready_i  in   1                      from shell pl_to_ps_fifo_ready_o
//  busy_o        out  1                      state != IDLE
//  grant_id_o    out  $clog2(num_req_p)      current/last granted requester
//  pkt_count_o   out  num_req_p*32           per-requester packet counts (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=IDLE, rr pointer so req 0 wins
//   first, grant_id_o=0, all outputs 0, counters 0.
//  States: IDLE -> HEADER -> PAYLOAD -> IDLE.
//  IDLE: fifo_v_o=0. If |req_v_i: pick first valid at/after (last_grant+1) mod
//   num_req_p; register id and req_len_i[id]; go HEADER next cycle. Else stay.
//  HEADER: fifo_v_o=1, fifo_data_o = header: bits[data_width_p-1 -: 8]=id
//   (zero-ext), bits[15:0]=len (zero-ext), others 0. Registered; stable until
//   fifo_ready_i. On v&ready: len==0 -> IDLE, else PAYLOAD with remaining=len.
//  PAYLOAD: fifo_v_o=req_v_i[id], fifo_data_o=req_data_i[id],
//   req_yumi_o[id]=req_v_i[id]&fifo_ready_i; each yumi decrements remaining;
//   yumi with remaining==1 -> IDLE. Requester dropping v stalls packet; grant is
//   never preempted; other requesters wait.
//  req_yumi_o is zero except in PAYLOAD for the granted id; at most one-hot.
//  Latency: req_v_i rise in IDLE -> header valid next cycle. Min one IDLE cycle
//   between packets; peak throughput = (len+1)/(len+2) words/cycle.
//  len > max_len_p: illegal input; assertion fires in simulation.
//  req_len_i sampled only at grant; later changes ignored for that packet.
//  Reset mid-packet: packet truncated at the FIFO (software discards on reset);
//   arbitration restarts at req 0.
//  fifo_data_o in IDLE is 0.
// CONFIGURATION
//  ZYNQ_PKT_ARB_STATS_EN defined: one 32-bit counter per requester, +1 when that
//   requester's packet completes (header accepted with len 0, or final payload
//   yumi); wraps 0xFFFF_FFFF -> 0; cleared by reset; driven on pkt_count_o
//   (intended for shell csr_data_i). Undefined: no counters, pkt_count_o tied 0.
// STRUCTURE
//  Package zynq_pkt_arb_pkg: state enum {e_idle,e_header,e_payload}; header
//   field constants (id_width 8, len_width 16, id msb position); header build fn.
//  Sub-module: zynq_rr_arb (round-robin pick: v vector + last-grant in, one-hot
//   + id out, combinational); state, counters, mux in this module.
// TESTING
//  1 req0 v, len=2, data 0xA then 0xB, ready=1 -> fifo sees 0x0000_0002, 0xA,
//    0xB on consecutive cycles; req_yumi_o[0] pulses twice; busy_o low after.
//  2 all 4 req v, len=1, held -> headers ids 0,1,2,3,0 in order (0x0100_0001..);
//    exactly one yumi per packet.
//  3 ready=0 for 5 cycles while in HEADER -> fifo_v_o=1, data stable, no yumi;
//    header accepted the cycle ready rises.
//  4 req2 len=0 -> single header 0x0200_0000, no yumi, back to IDLE; with
//    ZYNQ_PKT_ARB_STATS_EN pkt_count_o[2]=1.
//  5 req1 len=3 drops v after first word for 4 cycles, req3 v meanwhile ->
//    fifo_v_o=0, grant stays 1, req3 served only after req1's 3rd word.
//  6 aresetn low during PAYLOAD -> all outputs 0 same cycle; after release, req
//    0 and 1 both v -> req0 granted first; counters 0.

Source files
------------

// File: rtl/zynq_pkt_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zynq_pkt_arb_pkg
//  Purpose  : Shared types, header field layout and header builder for the
//             PL->PS packet arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package zynq_pkt_arb_pkg;

    typedef enum logic [1:0] {
        e_idle    = 2'd0,
        e_header  = 2'd1,
        e_payload = 2'd2
    } state_e;

    localparam int HDR_ID_WIDTH  = 8;
    localparam int HDR_LEN_WIDTH = 16;

    // The id field sits at the top of the word regardless of the bus width.
    function automatic int hdr_id_msb(input int data_width);
        return data_width - 1;
    endfunction

    function automatic logic [HDR_ID_WIDTH+HDR_LEN_WIDTH-1:0] hdr_fields(
        input logic [HDR_ID_WIDTH-1:0]  id,
        input logic [HDR_LEN_WIDTH-1:0] len
    );
        return {id, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/zynq_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zynq_rr_arb
//  Purpose  : Combinational round-robin pick: first valid requester strictly
//             after last_i (wrapping), returned as one-hot and as an index.
//  Revision : 1.0  initial release
// ============================================================================
module zynq_rr_arb #(
    parameter int num_req_p  = 4,
    parameter int id_width_p = 2
) (
    input  logic [num_req_p-1:0]  v_i,
    input  logic [id_width_p-1:0] last_i,
    output logic [num_req_p-1:0]  grant_oh_o,
    output logic [id_width_p-1:0] id_o,
    output logic                  v_o
);

    always_comb begin
        int  idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        grant_oh_o = '0;
        id_o       = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = (int'(last_i) + i) % num_req_p;
            if (!found && v_i[idx]) begin
                found           = 1'b1;
                id_o            = id_width_p'(idx);
                grant_oh_o[idx] = 1'b1;
            end
        end
        v_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/zynq_pl_to_ps_packet_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zynq_pl_to_ps_packet_arbiter
//  Purpose  : Round-robin packetiser sharing one PL->PS FIFO between
//             requesters: header word, then the granted payload, unbroken.
//             Define ZYNQ_PKT_ARB_STATS_EN for per-requester packet counters.
//  Revision : 1.0  initial release
// ============================================================================
module zynq_pl_to_ps_packet_arbiter
    import zynq_pkt_arb_pkg::*;
#(
    parameter int num_req_p    = 4,
    parameter int data_width_p = 32,
    parameter int max_len_p    = 16,
    localparam int lg_len_lp   = $clog2(max_len_p + 1),
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p*lg_len_lp-1:0]    req_len_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic [data_width_p-1:0]           fifo_data_o,
    output logic                              fifo_v_o,
    input  logic                              fifo_ready_i,
    output logic                              busy_o,
    output logic [id_width_lp-1:0]            grant_id_o,
    output logic [num_req_p*32-1:0]           pkt_count_o
);

    localparam int HDR_ID_MSB = hdr_id_msb(data_width_p);
    localparam int HDR_FIELDS = HDR_ID_WIDTH + HDR_LEN_WIDTH;

    state_e                  state_q, state_d;
    logic [id_width_lp-1:0]  id_q, id_d;
    logic [id_width_lp-1:0]  rr_q, rr_d;
    logic [num_req_p-1:0]    oh_q, oh_d;
    logic [lg_len_lp-1:0]    cnt_q, cnt_d;

    logic [data_width_p-1:0] w_data [num_req_p];
    logic [lg_len_lp-1:0]    w_len  [num_req_p];
    logic [num_req_p-1:0]    w_arb_oh;
    logic [id_width_lp-1:0]  w_arb_id;
    logic                    w_arb_v;
    logic                    w_pay_v;
    logic                    w_pay_fire;
    logic [HDR_FIELDS-1:0]   w_fields;
    logic [data_width_p-1:0] w_hdr;

    for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
        assign w_data[i] = req_data_i[i*data_width_p +: data_width_p];
        assign w_len[i]  = req_len_i[i*lg_len_lp +: lg_len_lp];
    end

    zynq_rr_arb #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_lp)
    ) u_rr_arb (
        .v_i        (req_v_i),
        .last_i     (rr_q),
        .grant_oh_o (w_arb_oh),
        .id_o       (w_arb_id),
        .v_o        (w_arb_v)
    );

    // cnt_q holds the packet length while in HEADER, so the header is built
    // purely from registers and stays stable under back-pressure.
    assign w_fields = hdr_fields(HDR_ID_WIDTH'(id_q), HDR_LEN_WIDTH'(cnt_q));

    always_comb begin
        w_hdr                                  = '0;
        w_hdr[HDR_ID_MSB -: HDR_ID_WIDTH]      = w_fields[HDR_FIELDS-1 -: HDR_ID_WIDTH];
        w_hdr[HDR_LEN_WIDTH-1:0]               = w_fields[HDR_LEN_WIDTH-1:0];
    end

    assign w_pay_v    = |(req_v_i & oh_q);
    assign w_pay_fire = (state_q == e_payload) && w_pay_v && fifo_ready_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= e_idle;
            id_q    <= '0;
            rr_q    <= id_width_lp'(num_req_p - 1);
            oh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_d        = rr_q;
        oh_d        = oh_q;
        cnt_d       = cnt_q;
        fifo_v_o    = 1'b0;
        fifo_data_o = '0;
        req_yumi_o  = '0;
        unique case (state_q)
            e_idle: begin
                if (w_arb_v) begin
                    state_d = e_header;
                    id_d    = w_arb_id;
                    rr_d    = w_arb_id;
                    oh_d    = w_arb_oh;
                    cnt_d   = w_len[w_arb_id];
                end
            end
            e_header: begin
                fifo_v_o    = 1'b1;
                fifo_data_o = w_hdr;
                if (fifo_ready_i) begin
                    state_d = (cnt_q == '0) ? e_idle : e_payload;
                end
            end
            e_payload: begin
                fifo_v_o    = w_pay_v;
                fifo_data_o = w_data[id_q];
                if (w_pay_fire) begin
                    req_yumi_o = oh_q;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == lg_len_lp'(1)) begin
                        state_d = e_idle;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    assign busy_o     = (state_q != e_idle);
    assign grant_id_o = id_q;

`ifdef ZYNQ_PKT_ARB_STATS_EN
    logic w_pkt_done;
    assign w_pkt_done = ((state_q == e_header) && fifo_ready_i && (cnt_q == '0))
                      || (w_pay_fire && (cnt_q == lg_len_lp'(1)));

    for (genvar i = 0; i < num_req_p; i++) begin : g_stats
        logic [31:0] pkt_cnt_q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                pkt_cnt_q <= '0;
            end else if (w_pkt_done && oh_q[i]) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
        assign pkt_count_o[i*32 +: 32] = pkt_cnt_q;
    end
`else
    assign pkt_count_o = '0;
`endif

    always_ff @(posedge aclk) begin
        if (aresetn && (state_q == e_idle) && w_arb_v) begin
            assert (int'(w_len[w_arb_id]) <= max_len_p)
                else $error("packet length exceeds max_len_p");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zynq_pl_to_ps_packet_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_zynq_pl_to_ps_packet_arbiter
//  Purpose  : Scoreboard bench for the PL->PS packet arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zynq_pl_to_ps_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int ML = 16;
    localparam int LL = 5;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    req_v_i;
    logic [N*DW-1:0] req_data_i;
    logic [N*LL-1:0] req_len_i;
    logic [N-1:0]    req_yumi_o;
    logic [DW-1:0]   fifo_data_o;
    logic            fifo_v_o;
    logic            fifo_ready_i;
    logic            busy_o;
    logic [1:0]      grant_id_o;
    logic [N*32-1:0] pkt_count_o;

    always #5 aclk = ~aclk;

    zynq_pl_to_ps_packet_arbiter #(
        .num_req_p    (N),
        .data_width_p (DW),
        .max_len_p    (ML)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req_v_i      (req_v_i),
        .req_data_i   (req_data_i),
        .req_len_i    (req_len_i),
        .req_yumi_o   (req_yumi_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_v_o     (fifo_v_o),
        .fifo_ready_i (fifo_ready_i),
        .busy_o       (busy_o),
        .grant_id_o   (grant_id_o),
        .pkt_count_o  (pkt_count_o)
    );

    logic [31:0]   dq [N][$];
    logic [LL-1:0] lenr [N];
    logic [N-1:0]  stall, zl;
    logic [31:0]   sb [$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;

    logic          s_fire, s_have;
    logic [31:0]   s_data, s_exp;
    logic [N-1:0]  s_yumi;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_v_i[i]              = ((dq[i].size() > 0) || zl[i]) && !stall[i];
            req_data_i[i*DW +: DW]  = (dq[i].size() > 0) ? dq[i][0] : 32'h0;
            req_len_i[i*LL +: LL]   = lenr[i];
        end
    endtask

    // Queue a packet's words at requester id and its expected FIFO image.
    task automatic add_pkt(input int id, input int len, input logic [31:0] base);
        lenr[id] = LL'(len);
        sb.push_back({8'(id), 8'h00, 16'(len)});
        for (int k = 0; k < len; k++) begin
            dq[id].push_back(base + 32'(k));
            sb.push_back(base + 32'(k));
        end
    endtask

    task automatic step();
        @(negedge aclk);
        cyc++;
        s_fire = fifo_v_o && fifo_ready_i;
        s_data = fifo_data_o;
        s_yumi = req_yumi_o;
        s_have = 1'b0;
        s_exp  = 32'h0;
        if (s_fire && sb.size() > 0) begin
            s_exp  = sb.pop_front();
            s_have = 1'b1;
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_yumi[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        aresetn      = 1'b0;
        fifo_ready_i = 1'b1;
        stall        = '0;
        zl           = '0;
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            lenr[i] = '0;
        end
        sb.delete();
        drive_inputs();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (busy_o !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        n_cmp++; if (fifo_v_o !== 1'b0)    begin n_bad++; $display("FAIL rst_fifo_v: got %b expected 0", fifo_v_o); end
        n_cmp++; if (fifo_data_o !== '0)   begin n_bad++; $display("FAIL rst_data: got %h expected 0", fifo_data_o); end
        n_cmp++; if (req_yumi_o !== '0)    begin n_bad++; $display("FAIL rst_yumi: got %b expected 0", req_yumi_o); end
        n_cmp++; if (grant_id_o !== 2'd0)  begin n_bad++; $display("FAIL rst_grant: got %0d expected 0", grant_id_o); end
        n_cmp++; if (pkt_count_o !== '0)   begin n_bad++; $display("FAIL rst_count: got %h expected 0", pkt_count_o); end
    endtask

    task automatic test_single_packet();
        int n_yumi, first_c, last_c, n_fire;
        n_yumi = 0; first_c = 0; last_c = 0; n_fire = 0;
        apply_reset();
        add_pkt(0, 2, 32'hA);
        drive_inputs();
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            step();
            if (s_yumi[0]) n_yumi++;
            if (s_fire) begin
                if (n_fire == 0) first_c = cyc;
                last_c = cyc;
                n_fire++;
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL single_word: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL single_drain: %0d words left, expected 0", sb.size()); end
        n_cmp++; if (n_yumi != 2)    begin n_bad++; $display("FAIL single_yumi: got %0d pulses expected 2", n_yumi); end
        n_cmp++; if (last_c - first_c != 2) begin n_bad++; $display("FAIL single_consec: span %0d expected 2", last_c - first_c); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b expected 0", busy_o); end
    endtask

    task automatic test_round_robin();
        int n_yumi;
        n_yumi = 0;
        apply_reset();
        add_pkt(0, 1, 32'h100);
        add_pkt(1, 1, 32'h110);
        add_pkt(2, 1, 32'h120);
        add_pkt(3, 1, 32'h130);
        add_pkt(0, 1, 32'h101);
        drive_inputs();
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            step();
            n_yumi += $countones(s_yumi);
            if (s_fire) begin
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL rr_word: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rr_drain: %0d words left, expected 0", sb.size()); end
        n_cmp++; if (n_yumi != 5)    begin n_bad++; $display("FAIL rr_yumi_total: got %0d expected 5", n_yumi); end
`ifdef ZYNQ_PKT_ARB_STATS_EN
        n_cmp++; if (pkt_count_o !== {32'd1, 32'd1, 32'd1, 32'd2}) begin n_bad++; $display("FAIL rr_counts: got %h expected 1,1,1,2", pkt_count_o); end
`else
        n_cmp++; if (pkt_count_o !== '0) begin n_bad++; $display("FAIL rr_counts: got %h expected 0", pkt_count_o); end
`endif
    endtask

    task automatic test_header_backpressure();
        apply_reset();
        fifo_ready_i = 1'b0;
        add_pkt(0, 1, 32'h33);
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if (fifo_v_o !== 1'b1 || s_data !== 32'h0000_0001) begin n_bad++; $display("FAIL bp_hold c%0d: v=%b data=%h expected v=1 data=00000001", c, fifo_v_o, s_data); end
            n_cmp++; if (s_yumi !== '0) begin n_bad++; $display("FAIL bp_yumi c%0d: got %b expected 0", c, s_yumi); end
        end
        fifo_ready_i = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step();
            if (s_fire) begin
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL bp_word: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL bp_drain: %0d words left, expected 0", sb.size()); end
    endtask

    task automatic test_zero_length();
        logic seen_yumi;
        seen_yumi = 1'b0;
        apply_reset();
        add_pkt(2, 0, 32'h0);
        zl[2] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step();
            if (s_yumi != '0) seen_yumi = 1'b1;
            if (s_fire) begin
                zl[2] = 1'b0;
                drive_inputs();
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL zl_header: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
        end
        step();
        n_cmp++; if (sb.size() != 0)  begin n_bad++; $display("FAIL zl_drain: %0d words left, expected 0", sb.size()); end
        n_cmp++; if (seen_yumi)       begin n_bad++; $display("FAIL zl_yumi: got a yumi expected none"); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL zl_busy: got %b expected 0", busy_o); end
`ifdef ZYNQ_PKT_ARB_STATS_EN
        n_cmp++; if (pkt_count_o[2*32 +: 32] !== 32'd1) begin n_bad++; $display("FAIL zl_count: got %0d expected 1", pkt_count_o[2*32 +: 32]); end
`else
        n_cmp++; if (pkt_count_o !== '0) begin n_bad++; $display("FAIL zl_count: got %h expected 0", pkt_count_o); end
`endif
    endtask

    task automatic test_payload_stall();
        int   w1;
        logic stalled;
        w1 = 0; stalled = 1'b0;
        apply_reset();
        add_pkt(1, 3, 32'h11);
        drive_inputs();
        step();
        if (s_fire) begin
            n_cmp++;
            if (!s_have || s_data !== s_exp) begin n_bad++; $display("FAIL stall_word: got %h expected %h", s_data, s_exp); end
        end
        add_pkt(3, 1, 32'h31);
        drive_inputs();
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            step();
            if (s_yumi[1]) w1++;
            if (s_fire) begin
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL stall_word: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
            if (w1 == 1 && !stalled) begin
                stalled  = 1'b1;
                stall[1] = 1'b1;
                drive_inputs();
                for (int k = 0; k < 4; k++) begin
                    step();
                    n_cmp++; if (fifo_v_o !== 1'b0 || s_fire) begin n_bad++; $display("FAIL stall_v k%0d: got %b expected 0", k, fifo_v_o); end
                    n_cmp++; if (grant_id_o !== 2'd1)         begin n_bad++; $display("FAIL stall_grant k%0d: got %0d expected 1", k, grant_id_o); end
                    n_cmp++; if (s_yumi !== '0)               begin n_bad++; $display("FAIL stall_yumi k%0d: got %b expected 0", k, s_yumi); end
                end
                stall[1] = 1'b0;
                drive_inputs();
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stall_drain: %0d words left, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_packet();
        logic got;
        got = 1'b0;
        apply_reset();
        add_pkt(0, 4, 32'h600);
        drive_inputs();
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (s_yumi[0]) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL mid_reach_payload: got no payload yumi, expected one"); end
        aresetn = 1'b0;
        #1;
        n_cmp++; if (fifo_v_o !== 1'b0 || fifo_data_o !== '0) begin n_bad++; $display("FAIL mid_fifo: got v=%b data=%h expected 0/0", fifo_v_o, fifo_data_o); end
        n_cmp++; if (req_yumi_o !== '0 || busy_o !== 1'b0)    begin n_bad++; $display("FAIL mid_yumi_busy: got yumi=%b busy=%b expected 0/0", req_yumi_o, busy_o); end
        n_cmp++; if (grant_id_o !== 2'd0 || pkt_count_o !== '0) begin n_bad++; $display("FAIL mid_grant_cnt: got grant=%0d cnt=%h expected 0/0", grant_id_o, pkt_count_o); end
        apply_reset();
        add_pkt(0, 1, 32'h700);
        add_pkt(1, 1, 32'h710);
        drive_inputs();
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            step();
            if (s_fire) begin
                n_cmp++;
                if (!s_have || s_data !== s_exp) begin
                    n_bad++; $display("FAIL mid_after_word: got %h expected %h (scoreboard had=%0d)", s_data, s_exp, s_have);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL mid_after_drain: %0d words left, expected 0", sb.size()); end
    endtask

    initial begin
        aresetn      = 1'b0;
        fifo_ready_i = 1'b1;
        req_v_i      = '0;
        req_data_i   = '0;
        req_len_i    = '0;
        stall        = '0;
        zl           = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_header_backpressure();
        test_zero_length();
        test_payload_stall();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
